aes_fifo_ctrl: RTL and testbench
================================

// Module: aes_fifo_ctrl
// PURPOSE
//  Sequences one AES block per pass: reads 16 bytes from the byte-wide input FIFO and packs them into 128 bits.
//  Hands the block to the AES core with a start/done handshake.
//  Unpacks the 128-bit result into the byte-wide output FIFO.
//  Sits between the host-side FIFOs and the AES core; it is the only master of those FIFO read/write enables.
// PARAMETERS
//  BYTE_W       8     FIFO data width; fixed, BLOCK_BYTES*BYTE_W must equal 128
//  BLOCK_BYTES  16    bytes per AES block
//  CNT_W        16    width of blk_cnt
//  TIMEOUT_CYC  1024  WAIT-state watchdog limit; used only with AES_FIFO_CTRL_TIMEOUT_EN
// PORTS
//  clk          in   1       clock, rising edge
//  rstn         in   1       async active-low reset
//  enable       in   1       allow a new block to start; sampled in IDLE only
//  in_rd_en     out  1       read strobe to the input FIFO
//  in_dout      in   8       input FIFO data; valid the cycle after a read that was accepted
//  in_empty     in   1       input FIFO empty flag
//  aes_start    out  1       one-cycle start pulse to the AES core
//  aes_din      out  128     block to the core; stable from START until the next LOAD
//  aes_done     in   1       core result valid (single-cycle pulse)
//  aes_dout     in   128     core result; sampled when aes_done is high
//  out_wr_en    out  1       write strobe to the output FIFO
//  out_din      out  8       output FIFO data
//  out_full     in   1       output FIFO full flag
//  busy         out  1       high in any state other than IDLE
//  blk_cnt      out  CNT_W   completed-block count; wraps modulo 2^CNT_W
//  err          out  1       sticky timeout error; tied to 0 without the macro
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (aes_din, blk_cnt and err included); both byte counters 0; the partial block is discarded.
//  FSM:
//   IDLE  -> LOAD  when enable=1.
//   LOAD  -> START the cycle after the 16th byte is captured.
//   START -> WAIT  unconditionally; aes_start=1 for this cycle only.
//   WAIT  -> DRAIN on aes_done=1; aes_dout is latched in that cycle.
//   DRAIN -> IDLE  after the 16th accepted write; blk_cnt increments by 1 in the same cycle.
//  LOAD read side:
//   in_rd_en = (state==LOAD) && !in_empty && (rd_issued < 16). The term is combinational on in_empty.
//   The block never issues more than 16 reads per block. Back-to-back reads are allowed: one per cycle.
//   rd_pending <= in_rd_en. When rd_pending=1, in_dout shifts in MSB-first: byte 0 lands in aes_din[127:120].
//   in_dout is ignored when rd_pending=0 (the FIFO drives 0 then).
//   Best case: 16 read cycles, 1 capture-tail cycle, then START.
//  WAIT:
//   aes_done is ignored in START and IDLE; only WAIT accepts it.
//   aes_done during reset is ignored.
//  DRAIN:
//   out_wr_en = (state==DRAIN) && !out_full. out_din = result byte wr_idx, MSB-first (byte 0 = bits [127:120]).
//   wr_idx advances only on an accepted write. out_full=1 stalls DRAIN indefinitely with no data loss.
//  enable is not checked after IDLE: a started block always completes, or times out.
//  blk_cnt wraps from 2^CNT_W-1 to 0 without any flag.
// CONFIGURATION
//  AES_FIFO_CTRL_TIMEOUT_EN defined:
//   A counter runs in WAIT. If it reaches TIMEOUT_CYC without aes_done, then err<=1 (sticky until rstn) and state->IDLE.
//   The block is discarded, blk_cnt is unchanged and no output writes occur.
//   A late aes_done arriving in IDLE is ignored.
//  Not defined: err is tied to 0 and WAIT waits forever; no counter logic is present.
// STRUCTURE
//  Package aes_fifo_pkg:
//   typedef enum ctrl_state_e {IDLE, LOAD, START, WAIT, DRAIN}
//   localparams BLOCK_BITS=128, BYTE_W=8, BLOCK_BYTES=16
//  Sub-module block_shifter: 128-bit register with parallel load and an 8-bit MSB-first shift.
//   Instantiated twice: once as the load shifter (shift-in) and once as the drain shifter (parallel load from aes_dout, shift-out).
//  No FIFO or AES core is instantiated inside this block.
// TESTING
//  T1: 16 bytes 0x00..0x0F preloaded, enable=1
//      -> in_rd_en high for 16 consecutive cycles; aes_din=128'h000102...0F; exactly one aes_start pulse.
//  T2: core returns aes_dout=128'hA0A1..AF after 5 cycles, out_full=0
//      -> 16 writes A0..AF in order on consecutive cycles; blk_cnt=1; busy falls afterwards.
//  T3: input FIFO runs empty after byte 7, refilled 10 cycles later
//      -> in_rd_en drops while in_empty=1; exactly 16 reads in total; bytes are not reordered.
//  T4: out_full asserted during writes 3..8 of DRAIN
//      -> out_wr_en=0 while full; all 16 bytes still appear in order; no duplicates.
//  T5: rstn pulsed low in WAIT and again mid-LOAD
//      -> outputs return to 0 immediately; the next block loads cleanly from byte 0.
//  T6 (macro on, TIMEOUT_CYC=8): aes_done withheld
//      -> err=1 after 8 WAIT cycles; state IDLE; blk_cnt unchanged; no out_wr_en.
//      Macro off: busy stays high and err stays 0.

Source files
------------

// File: rtl/aes_fifo_pkg.sv
// Shared types and constants for the AES FIFO sequencer.
package aes_fifo_pkg;

    localparam int BLOCK_BITS  = 128;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/block_shifter.sv
// Block-wide register with parallel load and a byte-wide MSB-first shift.
// Load takes priority over shift when both are requested.
module block_shifter
    import aes_fifo_pkg::*;
#(
    parameter int W = BLOCK_BITS,
    parameter int B = BYTE_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic [B-1:0] shift_data_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q;

    // Block register: new bytes enter at the LSB end so byte 0 ends up on top.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= {data_q[W-B-1:0], shift_data_i};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/aes_fifo_ctrl.sv
// Moves one AES block per pass: input FIFO -> 128-bit pack -> core -> byte unpack -> output FIFO.
// Optional WAIT watchdog with sticky err is enabled by defining AES_FIFO_CTRL_TIMEOUT_EN.
module aes_fifo_ctrl #(
    parameter int BYTE_W      = aes_fifo_pkg::BYTE_W,
    parameter int BLOCK_BYTES = aes_fifo_pkg::BLOCK_BYTES,
    parameter int CNT_W       = 16
`ifdef AES_FIFO_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    output logic                          in_rd_en,
    input  logic [BYTE_W-1:0]             in_dout,
    input  logic                          in_empty,
    output logic                          aes_start,
    output logic [BLOCK_BYTES*BYTE_W-1:0] aes_din,
    input  logic                          aes_done,
    input  logic [BLOCK_BYTES*BYTE_W-1:0] aes_dout,
    output logic                          out_wr_en,
    output logic [BYTE_W-1:0]             out_din,
    input  logic                          out_full,
    output logic                          busy,
    output logic [CNT_W-1:0]              blk_cnt,
    output logic                          err
);

    import aes_fifo_pkg::*;

    localparam int BITS = BLOCK_BYTES * BYTE_W;
    localparam int RD_W = $clog2(BLOCK_BYTES + 1);
    localparam int WR_W = $clog2(BLOCK_BYTES);
    localparam logic [RD_W-1:0]  RD_LAST = RD_W'(BLOCK_BYTES);
    localparam logic [RD_W-1:0]  RD_ONE  = RD_W'(1);
    localparam logic [WR_W-1:0]  WR_LAST = WR_W'(BLOCK_BYTES - 1);
    localparam logic [WR_W-1:0]  WR_ONE  = WR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_state_e       state_q, state_d;
    logic [RD_W-1:0]   rd_issued_q, rd_issued_d;
    logic              rd_pending_q;
    logic [WR_W-1:0]   wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              drain_load_s;
    logic              drain_shift_s;
    logic [BITS-1:0]   load_data_s;
    logic [BITS-1:0]   drain_data_s;
    logic [BITS-BYTE_W-1:0] drain_rest_unused;

`ifdef AES_FIFO_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    // Next-state, FIFO strobes and shifter controls.
    always_comb begin
        state_d       = state_q;
        rd_issued_d   = rd_issued_q;
        wr_idx_d      = wr_idx_q;
        blk_cnt_d     = blk_cnt_q;
        in_rd_en      = 1'b0;
        out_wr_en     = 1'b0;
        drain_load_s  = 1'b0;
        drain_shift_s = 1'b0;
`ifdef AES_FIFO_CTRL_TIMEOUT_EN
        tmo_cnt_d     = '0;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                rd_issued_d = '0;
                wr_idx_d    = '0;
                if (enable) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (!in_empty && (rd_issued_q != RD_LAST)) begin
                    in_rd_en    = 1'b1;
                    rd_issued_d = rd_issued_q + RD_ONE;
                end else begin
                    in_rd_en    = 1'b0;
                end
                // The last byte is being captured this cycle when all reads are out and one is pending.
                if (rd_pending_q && (rd_issued_q == RD_LAST)) begin
                    state_d = START;
                end else begin
                    state_d = LOAD;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (aes_done) begin
                    drain_load_s = 1'b1;
                    wr_idx_d     = '0;
                    state_d      = DRAIN;
                end
`ifdef AES_FIFO_CTRL_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    state_d   = WAIT;
                end
`else
                else begin
                    state_d = WAIT;
                end
`endif
            end
            DRAIN: begin
                if (!out_full) begin
                    out_wr_en     = 1'b1;
                    drain_shift_s = 1'b1;
                    wr_idx_d      = wr_idx_q + WR_ONE;
                    if (wr_idx_q == WR_LAST) begin
                        blk_cnt_d = blk_cnt_q + CNT_ONE;
                        state_d   = IDLE;
                    end else begin
                        state_d   = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rd_issued_q  <= '0;
            rd_pending_q <= 1'b0;
            wr_idx_q     <= '0;
            blk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_issued_q  <= rd_issued_d;
            rd_pending_q <= in_rd_en;
            wr_idx_q     <= wr_idx_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

`ifdef AES_FIFO_CTRL_TIMEOUT_EN
    // WAIT watchdog and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    block_shifter #(
        .W (BITS),
        .B (BYTE_W)
    ) u_load_shifter (
        .clk          (clk),
        .rstn         (rstn),
        .load_i       (1'b0),
        .load_data_i  ({BITS{1'b0}}),
        .shift_i      (rd_pending_q),
        .shift_data_i (in_dout),
        .data_o       (load_data_s)
    );

    block_shifter #(
        .W (BITS),
        .B (BYTE_W)
    ) u_drain_shifter (
        .clk          (clk),
        .rstn         (rstn),
        .load_i       (drain_load_s),
        .load_data_i  (aes_dout),
        .shift_i      (drain_shift_s),
        .shift_data_i ({BYTE_W{1'b0}}),
        .data_o       (drain_data_s)
    );

    assign {out_din, drain_rest_unused} = drain_data_s;
    assign aes_din   = load_data_s;
    assign aes_start = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_aes_fifo_ctrl.sv
// Self-checking bench for aes_fifo_ctrl: models both FIFOs and the AES core around the DUT.
module tb_aes_fifo_ctrl;

    logic         clk = 1'b0;
    logic         rstn;
    logic         enable;
    logic         in_rd_en;
    logic [7:0]   in_dout;
    logic         in_empty;
    logic         aes_start;
    logic [127:0] aes_din;
    logic         aes_done;
    logic [127:0] aes_dout;
    logic         out_wr_en;
    logic [7:0]   out_din;
    logic         out_full;
    logic         busy;
    logic [15:0]  blk_cnt;
    logic         err;

    aes_fifo_ctrl #(
        .CNT_W (16)
`ifdef AES_FIFO_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .in_rd_en  (in_rd_en),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .aes_start (aes_start),
        .aes_din   (aes_din),
        .aes_done  (aes_done),
        .aes_dout  (aes_dout),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .out_full  (out_full),
        .busy      (busy),
        .blk_cnt   (blk_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] blk;
        int           gap_at;
        int           gap_len;
        logic [127:0] res;
        int           lat;
        int           full_at;
        int           full_len;
        logic [127:0] exp_din;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [7:0]   inq[$];
    logic [7:0]   outq[$];
    logic [7:0]   rd_byte;
    logic [127:0] core_res;
    logic [127:0] din_cap;
    bit   rd_prev, done_armed, done_withheld;
    int   cyc, rd_cnt, wr_cnt, starts, viol;
    int   first_rd, last_rd, first_wr, last_wr;
    int   gap_at, gap_left, full_at, full_left, lat, done_cyc;
    int   model_cnt;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_q(input logic [7:0] q[$]);
        logic [127:0] r = '0;
        for (int i = 0; i < q.size(); i++) r = {r[119:0], q[i]};
        if (q.size() != 16) r = 'x;
        return r;
    endfunction

    task automatic clear_block();
        inq.delete(); outq.delete();
        rd_prev = 1'b0; rd_byte = 8'h00; done_armed = 1'b0; done_withheld = 1'b0;
        rd_cnt = 0; wr_cnt = 0; starts = 0; viol = 0;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        gap_at = -1; gap_left = 0; full_at = -1; full_left = 0; lat = 1; done_cyc = -1;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, model both FIFOs and the core.
    task automatic tick();
        bit gap_now;
        @(negedge clk);
        in_dout  = rd_prev ? rd_byte : 8'h00;
        gap_now  = (gap_at >= 0) && (rd_cnt == gap_at) && (gap_left > 0);
        in_empty = (inq.size() == 0) || gap_now;
        if (gap_now) gap_left--;
        out_full = (full_at >= 0) && (wr_cnt == full_at) && (full_left > 0);
        if (out_full) full_left--;
        aes_done = done_armed && (cyc == done_cyc);
        aes_dout = aes_done ? core_res : ~core_res;
        #1;
        if (in_rd_en && in_empty) viol++;
        if (out_wr_en && out_full) viol++;
        rd_prev = in_rd_en;
        if (in_rd_en && inq.size() > 0) begin
            rd_byte = inq.pop_front();
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (out_wr_en) begin
            outq.push_back(out_din);
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (aes_start) begin
            starts++;
            din_cap = aes_din;
            if (!done_withheld) begin
                done_armed = 1'b1;
                done_cyc   = cyc + lat;
            end
        end
        cyc++;
    endtask

    task automatic run_block(input string nm, input vec_t v);
        int  n;
        bit  was_busy;
        clear_block();
        for (int i = 0; i < 16; i++) inq.push_back(v.blk[127-8*i -: 8]);
        gap_at = v.gap_at;  gap_left = v.gap_len;
        full_at = v.full_at; full_left = v.full_len;
        core_res = v.res; lat = v.lat;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        was_busy = 1'b0;
        n = 0;
        while (n < 500) begin
            tick();
            if (busy) was_busy = 1'b1;
            else if (was_busy) break;
            n++;
        end
        model_cnt++;
        check({nm, " done_in_time"}, 128'(n < 500), 128'd1);
        check({nm, " aes_din"}, din_cap, v.exp_din);
        check({nm, " start_pulses"}, 128'(starts), 128'd1);
        check({nm, " reads"}, 128'(rd_cnt), 128'd16);
        check({nm, " out_bytes"}, pack_q(outq), v.res);
        check({nm, " blk_cnt"}, 128'(blk_cnt), 128'(model_cnt));
        check({nm, " protocol"}, 128'(viol), 128'd0);
        check({nm, " err"}, 128'(err), 128'd0);
        if (v.gap_at < 0) check({nm, " read_burst"}, 128'(last_rd - first_rd), 128'd15);
        if (v.full_at < 0) check({nm, " write_burst"}, 128'(last_wr - first_wr), 128'd15);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " in_rd_en"}, 128'(in_rd_en), 128'd0);
        check({nm, " aes_start"}, 128'(aes_start), 128'd0);
        check({nm, " aes_din"}, aes_din, 128'd0);
        check({nm, " out_wr_en"}, 128'(out_wr_en), 128'd0);
        check({nm, " out_din"}, 128'(out_din), 128'd0);
        check({nm, " busy"}, 128'(busy), 128'd0);
        check({nm, " blk_cnt"}, 128'(blk_cnt), 128'd0);
        check({nm, " err"}, 128'(err), 128'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        aes_done = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        aes_done = 1'b0;
        rstn = 1'b1;
        clear_block();
        model_cnt = 0;
    endtask

    vec_t vecs[4];

    initial begin
        vec_t  rv;
        logic [7:0] bq[$];
        int    n;

        vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, -1, 0,
                    128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 5, -1, 0,
                    128'h000102030405060708090A0B0C0D0E0F};
        vecs[1] = '{128'h101112131415161718191A1B1C1D1E1F, 8, 10,
                    128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 2, -1, 0,
                    128'h101112131415161718191A1B1C1D1E1F};
        vecs[2] = '{128'h202122232425262728292A2B2C2D2E2F, -1, 0,
                    128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 1, 2, 6,
                    128'h202122232425262728292A2B2C2D2E2F};
        vecs[3] = '{128'hFEDCBA98765432100123456789ABCDEF, 1, 3,
                    128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 7, 15, 4,
                    128'hFEDCBA98765432100123456789ABCDEF};

        clear_block();
        cyc = 0; model_cnt = 0; core_res = '0;
        rstn = 1'b0; enable = 1'b0; in_dout = 8'h00; in_empty = 1'b1;
        aes_done = 1'b1; aes_dout = '1; out_full = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        aes_done = 1'b0;
        rstn = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        for (int i = 0; i < 4; i++) run_block($sformatf("vec%0d", i), vecs[i]);

        for (int k = 0; k < 8; k++) begin
            bq.delete();
            for (int i = 0; i < 16; i++) bq.push_back(8'($urandom));
            rv.exp_din  = pack_q(bq);
            rv.blk      = rv.exp_din;
            rv.gap_at   = int'($urandom_range(0, 24));
            if (rv.gap_at > 15) rv.gap_at = -1;
            rv.gap_len  = int'($urandom_range(1, 6));
            rv.res      = {$urandom, $urandom, $urandom, $urandom};
            rv.lat      = int'($urandom_range(1, 12));
            rv.full_at  = int'($urandom_range(0, 24));
            if (rv.full_at > 15) rv.full_at = -1;
            rv.full_len = int'($urandom_range(1, 6));
            run_block($sformatf("rand%0d", k), rv);
        end

        // Reset while the core is busy; aes_done during reset must be ignored.
        clear_block();
        for (int i = 0; i < 16; i++) inq.push_back(8'(8'h80 + i));
        done_withheld = 1'b1;
        enable = 1'b1; tick(); enable = 1'b0;
        n = 0;
        while (starts == 0 && n < 100) begin tick(); n++; end
        check("wait_reached", 128'(starts), 128'd1);
        repeat (3) tick();
        pulse_reset();
        check_idle_outputs("rst_in_wait");
        release_reset();

        // Reset in the middle of LOAD.
        for (int i = 0; i < 16; i++) inq.push_back(8'(8'h40 + i));
        enable = 1'b1; tick(); enable = 1'b0;
        repeat (6) tick();
        check("mid_load_reads", 128'(rd_cnt > 0), 128'd1);
        pulse_reset();
        check_idle_outputs("rst_in_load");
        release_reset();
        rv = '{128'h5A5B5C5D5E5F606162636465666768FF, -1, 0,
               128'h00112233445566778899AABBCCDDEEFF, 3, -1, 0,
               128'h5A5B5C5D5E5F606162636465666768FF};
        run_block("after_reset", rv);

        // Withheld aes_done.
        clear_block();
        for (int i = 0; i < 16; i++) inq.push_back(8'(i * 3));
        done_withheld = 1'b1;
        enable = 1'b1; tick(); enable = 1'b0;
        n = 0;
        while (starts == 0 && n < 100) begin tick(); n++; end
        repeat (9) tick();
`ifdef AES_FIFO_CTRL_TIMEOUT_EN
        check("tmo_err", 128'(err), 128'd1);
        check("tmo_busy", 128'(busy), 128'd0);
        check("tmo_blk_cnt", 128'(blk_cnt), 128'(model_cnt));
        done_armed = 1'b1; done_cyc = cyc;
        repeat (20) tick();
        check("tmo_late_done_busy", 128'(busy), 128'd0);
        check("tmo_writes", 128'(wr_cnt), 128'd0);
        check("tmo_err_sticky", 128'(err), 128'd1);
`else
        repeat (40) tick();
        check("nodone_busy", 128'(busy), 128'd1);
        check("nodone_err", 128'(err), 128'd0);
        check("nodone_writes", 128'(wr_cnt), 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
